// File: rtl/connect4_pkg.sv
// Shared constants for the 4x4 Connect-4 board: cell encoding, win lines,
// winner codes and the recorder FSM state type.
package connect4_pkg;

   localparam logic [4:0] NO_MOVE = 5'd31;

   // Four rows, four columns, then the two diagonals.
   localparam logic [15:0] WIN_MASKS [10] = '{
      16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
      16'h1111, 16'h2222, 16'h4444, 16'h8888,
      16'h8421, 16'h1248
   };

   localparam logic [1:0] W_NONE = 2'b00;
   localparam logic [1:0] W_P1   = 2'b01;
   localparam logic [1:0] W_P2   = 2'b10;
   localparam logic [1:0] W_DRAW = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLACE = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic logic has_line(input logic [15:0] map);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if ((map & WIN_MASKS[i]) == WIN_MASKS[i]) found = 1'b1;
      end
      return found;
   endfunction

endpackage

// File: rtl/board_scanner.sv
// Row-multiplexed view of the board occupancy for a scanned display.
// Only instantiated when CONNECT4_SCAN_EN is defined.
module board_scanner
   import connect4_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] occ_p1,
   input  logic [15:0] occ_p2,
   output logic [3:0]  scan_row,
   output logic [3:0]  scan_p1,
   output logic [3:0]  scan_p2
);

   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [1:0]    row;
   logic [1:0]    row_nxt;

   assign row_nxt = (div_cnt == DIV_LAST) ? row + 2'd1 : row;

   // Row select and row data are registered from the same next-row value so
   // they always change on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt  <= '0;
         row      <= 2'd0;
         scan_row <= 4'b1110;
         scan_p1  <= 4'd0;
         scan_p2  <= 4'd0;
      end else begin
         div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         row      <= row_nxt;
         scan_row <= ~(4'b0001 << row_nxt);
         scan_p1  <= occ_p1[{row_nxt, 2'b00} +: 4];
         scan_p2  <= occ_p2[{row_nxt, 2'b00} +: 4];
      end
   end

endmodule

// File: rtl/board_recorder.sv
// Game-state keeper for the 4x4 Connect-4 board: legality check, placement,
// win/draw detection. Define CONNECT4_SCAN_EN to add the scanned row outputs.
module board_recorder
   import connect4_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        reset,
   // Handshake: a move transfers on a rising edge where move_valid and
   // move_ready are both high; move_valid is ignored while move_ready is low.
   input  logic        move_valid,
   input  logic [4:0]  move_pos,
   output logic        move_ready,
   output logic [15:0] occ_p1,
   output logic [15:0] occ_p2,
   output logic        current_player,
   output logic [1:0]  winner,
   output logic        game_over,
   output logic        illegal,
   output state_t      state_dbg
`ifdef CONNECT4_SCAN_EN
   ,
   output logic [3:0]  scan_row,
   output logic [3:0]  scan_p1,
   output logic [3:0]  scan_p2
`endif
);

   state_t      state, state_nxt;
   logic [3:0]  pos_q;
   logic [15:0] occ_all;
   logic        move_legal;
   logic        accept, reject, line_done, board_full;

   assign occ_all    = occ_p1 | occ_p2;
   assign line_done  = has_line(current_player ? occ_p2 : occ_p1);
   assign board_full = &occ_all;

   // A cell above row 0 needs the cell directly below it filled.
   assign move_legal = (move_pos < 5'd16) && !occ_all[move_pos[3:0]] &&
                       ((move_pos < 5'd4) || occ_all[move_pos[3:0] - 4'd4]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      reject    = 1'b0;
      case (state)
         S_IDLE: begin
            if (move_valid && move_pos != NO_MOVE) begin
               if (move_legal) begin
                  accept    = 1'b1;
                  state_nxt = S_PLACE;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         S_PLACE: state_nxt = S_CHECK;
         S_CHECK: state_nxt = (line_done || board_full) ? S_DONE : S_IDLE;
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_q          <= 4'd0;
         occ_p1         <= 16'd0;
         occ_p2         <= 16'd0;
         current_player <= 1'b0;
         winner         <= W_NONE;
         illegal        <= 1'b0;
      end else begin
         illegal <= reject;
         if (accept) pos_q <= move_pos[3:0];
         if (state == S_PLACE) begin
            if (current_player) occ_p2[pos_q] <= 1'b1;
            else                occ_p1[pos_q] <= 1'b1;
         end
         if (state == S_CHECK) begin
            if (line_done)       winner <= current_player ? W_P2 : W_P1;
            else if (board_full) winner <= W_DRAW;
            else                 current_player <= ~current_player;
         end
      end
   end

   assign move_ready = (state == S_IDLE);
   assign game_over  = (state == S_DONE);
   assign state_dbg  = state;

`ifdef CONNECT4_SCAN_EN
   board_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
      .clk      (clk),
      .reset    (reset),
      .occ_p1   (occ_p1),
      .occ_p2   (occ_p2),
      .scan_row (scan_row),
      .scan_p1  (scan_p1),
      .scan_p2  (scan_p2)
   );
`endif

endmodule
